// File: rtl/ysyx_25040118_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Holds the arbiter FSM encoding and the fixed master indices.
// No logic; imported by the arbiter and its sub-modules.
package ysyx_25040118_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int M_IFU = 0;
  localparam int M_LSU = 1;

endpackage

// File: rtl/ysyx_25040118_Reg.sv
// Generic register with synchronous active-high reset and write enable.
// Latency: one cycle from din/wen to dout.
// No flow control; holds its value whenever wen is low.
module ysyx_25040118_Reg #(
  parameter int             WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  // Reset wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_25040118_rr_pick.sv
// Two-way round-robin selector for the memory arbiter.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to commit the pick.
module ysyx_25040118_rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  // A lone requester wins outright; on a tie the master not granted last time wins.
  always_comb begin
    any = |valid;
    sel = (valid == 2'b11) ? ~last : valid[1];
  end

endmodule

// File: rtl/ysyx_25040118_mem_arbiter.sv
// Shares one memory port between IFU (master 0) and LSU (master 1), one transaction in flight.
// Latency: grant in IDLE, issue the next cycle, response passes through combinationally; 3 cycles minimum.
// s_req_ready low holds ISSUE, m_rsp_ready[owner] low holds WAIT; neither touches the arbitration state.
module ysyx_25040118_mem_arbiter
  import ysyx_25040118_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req_valid,
  output logic [1:0]              m_req_ready,
  input  logic [2*ADDR_W-1:0]     m_req_addr,
  input  logic [1:0]              m_req_wen,
  input  logic [2*DATA_W-1:0]     m_req_wdata,
  input  logic [2*(DATA_W/8)-1:0] m_req_wmask,
  output logic [1:0]              m_rsp_valid,
  input  logic [1:0]              m_rsp_ready,
  output logic [DATA_W-1:0]       m_rsp_rdata,
  output logic                    m_rsp_err,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  output logic [ADDR_W-1:0]       s_req_addr,
  output logic                    s_req_wen,
  output logic [DATA_W-1:0]       s_req_wdata,
  output logic [DATA_W/8-1:0]     s_req_wmask,
  input  logic                    s_rsp_valid,
  output logic                    s_rsp_ready,
  input  logic [DATA_W-1:0]       s_rsp_rdata,
  input  logic                    s_rsp_err
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [1:0]          state_raw;
  logic                owner_q, last_q;
  logic                pick_sel, pick_any;
  logic                grant;
  logic                sel_lsu;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_wen;
  logic [DATA_W-1:0]   sel_wdata;
  logic [MASK_W-1:0]   sel_wmask;

  ysyx_25040118_rr_pick u_pick (
    .valid (m_req_valid),
    .last  (last_q),
    .sel   (pick_sel),
    .any   (pick_any)
  );

  // A grant is the IDLE-state handshake; it is the only event that loads owner, last and the request latch.
  always_comb begin
    grant     = (state_q == ST_IDLE) && pick_any;
    sel_lsu   = (pick_sel == 1'(M_LSU));
    sel_addr  = sel_lsu ? m_req_addr[M_LSU*ADDR_W +: ADDR_W]  : m_req_addr[M_IFU*ADDR_W +: ADDR_W];
    sel_wen   = sel_lsu ? m_req_wen[M_LSU]                    : m_req_wen[M_IFU];
    sel_wdata = sel_lsu ? m_req_wdata[M_LSU*DATA_W +: DATA_W] : m_req_wdata[M_IFU*DATA_W +: DATA_W];
    sel_wmask = sel_lsu ? m_req_wmask[M_LSU*MASK_W +: MASK_W] : m_req_wmask[M_IFU*MASK_W +: MASK_W];
    state_q   = arb_state_e'(state_raw);
  end

  ysyx_25040118_Reg #(.WIDTH(2), .RESET_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst(rst), .din(state_d), .dout(state_raw), .wen(1'b1)
  );

  ysyx_25040118_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_owner (
    .clk(clk), .rst(rst), .din(pick_sel), .dout(owner_q), .wen(grant)
  );

  // last resets to 1 so the IFU wins the first tie.
  ysyx_25040118_Reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_last (
    .clk(clk), .rst(rst), .din(pick_sel), .dout(last_q), .wen(grant)
  );

  ysyx_25040118_Reg #(.WIDTH(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .din(sel_addr), .dout(s_req_addr), .wen(grant)
  );

  ysyx_25040118_Reg #(.WIDTH(1)) u_wen (
    .clk(clk), .rst(rst), .din(sel_wen), .dout(s_req_wen), .wen(grant)
  );

  ysyx_25040118_Reg #(.WIDTH(DATA_W)) u_wdata (
    .clk(clk), .rst(rst), .din(sel_wdata), .dout(s_req_wdata), .wen(grant)
  );

  ysyx_25040118_Reg #(.WIDTH(MASK_W)) u_wmask (
    .clk(clk), .rst(rst), .din(sel_wmask), .dout(s_req_wmask), .wen(grant)
  );

  // Next state and handshake outputs; responses are forwarded only in WAIT, and data is zeroed when not valid.
  always_comb begin
    state_d     = state_q;
    m_req_ready = 2'b00;
    s_req_valid = 1'b0;
    m_rsp_valid = 2'b00;
    s_rsp_ready = 1'b0;
    m_rsp_rdata = '0;
    m_rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          m_req_ready[pick_sel] = 1'b1;
          state_d               = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_req_valid = 1'b1;
        if (s_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        m_rsp_valid[owner_q] = s_rsp_valid;
        s_rsp_ready          = m_rsp_ready[owner_q];
        if (s_rsp_valid) begin
          m_rsp_rdata = s_rsp_rdata;
          m_rsp_err   = s_rsp_err;
        end
        if (s_rsp_valid && m_rsp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
